// File: rtl/chamber_sequencer.sv
// Airlock chamber fill/drain sequencer with port interlocks and countdown digit.
// Define CHAMBER_SEQ_HEX_EN to drive hex_count from the countdown; otherwise it is blank.
module chamber_sequencer #(
   parameter int unsigned FILL_CYCLES = 7,
   parameter int unsigned EVAC_CYCLES = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       pressurize_req,
   input  logic       evacuate_req,
   input  logic       inner_closed,
   input  logic       outer_closed,
   output logic       pressurized,
   output logic       busy,
   output logic       done,
   output logic       reject,
   output logic       fault,
   output logic       inner_unlock,
   output logic       outer_unlock,
   output logic [6:0] hex_count
);

   localparam int unsigned CNT_W = 4;
   localparam logic [6:0]  HEX_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      ST_EVACUATED   = 2'd0,
      ST_FILLING     = 2'd1,
      ST_PRESSURIZED = 2'd2,
      ST_EVACUATING  = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             reject_q, reject_d;
   logic             fault_q, fault_d;
   logic             busy_q, busy_d;
   logic             pressurized_q, pressurized_d;
   logic             inner_unlock_q, inner_unlock_d;
   logic             outer_unlock_q, outer_unlock_d;
   logic             ports_closed;
   logic             any_req;

   assign ports_closed = inner_closed & outer_closed;
   assign any_req      = pressurize_req | evacuate_req;

   // Next-state, countdown and one-cycle status pulses
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      reject_d = 1'b0;
      fault_d  = 1'b0;
      case (state_q)
         ST_EVACUATED: begin
            if (any_req) begin
               if (pressurize_req && !evacuate_req && ports_closed) begin
                  state_d = ST_FILLING;
                  cnt_d   = CNT_W'(FILL_CYCLES - 1);
               end else begin
                  reject_d = 1'b1;
               end
            end
         end
         ST_PRESSURIZED: begin
            if (any_req) begin
               if (evacuate_req && !pressurize_req && ports_closed) begin
                  state_d = ST_EVACUATING;
                  cnt_d   = CNT_W'(EVAC_CYCLES - 1);
               end else begin
                  reject_d = 1'b1;
               end
            end
         end
         ST_FILLING: begin
            reject_d = any_req;
            // An opened port aborts even on the final count
            if (!ports_closed) begin
               state_d = ST_EVACUATED;
               cnt_d   = '0;
               fault_d = 1'b1;
            end else if (cnt_q == '0) begin
               state_d = ST_PRESSURIZED;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_EVACUATING: begin
            reject_d = any_req;
            if (!ports_closed) begin
               state_d = ST_PRESSURIZED;
               cnt_d   = '0;
               fault_d = 1'b1;
            end else if (cnt_q == '0) begin
               state_d = ST_EVACUATED;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_EVACUATED;
            cnt_d   = '0;
         end
      endcase

      busy_d         = (state_d == ST_FILLING) || (state_d == ST_EVACUATING);
      pressurized_d  = (state_d == ST_PRESSURIZED);
      inner_unlock_d = (state_d == ST_PRESSURIZED);
      outer_unlock_d = (state_d == ST_EVACUATED);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= ST_EVACUATED;
         cnt_q          <= '0;
         done_q         <= 1'b0;
         reject_q       <= 1'b0;
         fault_q        <= 1'b0;
         busy_q         <= 1'b0;
         pressurized_q  <= 1'b0;
         inner_unlock_q <= 1'b0;
         outer_unlock_q <= 1'b1;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         done_q         <= done_d;
         reject_q       <= reject_d;
         fault_q        <= fault_d;
         busy_q         <= busy_d;
         pressurized_q  <= pressurized_d;
         inner_unlock_q <= inner_unlock_d;
         outer_unlock_q <= outer_unlock_d;
      end
   end

`ifdef CHAMBER_SEQ_HEX_EN
   logic [6:0] hex_count_q, hex_count_d;

   // Active-low {g,f,e,d,c,b,a} digit of the next countdown value
   always_comb begin
      hex_count_d = HEX_BLANK;
      if (busy_d) begin
         case (cnt_d)
            4'd0:    hex_count_d = 7'h40;
            4'd1:    hex_count_d = 7'h79;
            4'd2:    hex_count_d = 7'h24;
            4'd3:    hex_count_d = 7'h30;
            4'd4:    hex_count_d = 7'h19;
            4'd5:    hex_count_d = 7'h12;
            4'd6:    hex_count_d = 7'h02;
            4'd7:    hex_count_d = 7'h78;
            4'd8:    hex_count_d = 7'h00;
            4'd9:    hex_count_d = 7'h10;
            default: hex_count_d = HEX_BLANK;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) hex_count_q <= HEX_BLANK;
      else       hex_count_q <= hex_count_d;
   end

   assign hex_count = hex_count_q;
`else
   assign hex_count = HEX_BLANK;
`endif

   assign pressurized  = pressurized_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign reject       = reject_q;
   assign fault        = fault_q;
   assign inner_unlock = inner_unlock_q;
   assign outer_unlock = outer_unlock_q;

endmodule

// File: tb/tb_chamber_sequencer.sv
// Bench for chamber_sequencer: directed test-plan sequences then random stimulus,
// two parameterisations (7/8 and 1/3) checked against a remaining-cycles model.
module tb_chamber_sequencer;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic reset, pressurize_req, evacuate_req, inner_closed, outer_closed;
   logic [1:0] pressurized, busy, done, reject, fault, inner_unlock, outer_unlock;
   logic [6:0] hex_count [2];

   chamber_sequencer #(.FILL_CYCLES(7), .EVAC_CYCLES(8)) u_dut0 (
      .clock(clock), .reset(reset),
      .pressurize_req(pressurize_req), .evacuate_req(evacuate_req),
      .inner_closed(inner_closed), .outer_closed(outer_closed),
      .pressurized(pressurized[0]), .busy(busy[0]), .done(done[0]),
      .reject(reject[0]), .fault(fault[0]),
      .inner_unlock(inner_unlock[0]), .outer_unlock(outer_unlock[0]),
      .hex_count(hex_count[0])
   );

   chamber_sequencer #(.FILL_CYCLES(1), .EVAC_CYCLES(3)) u_dut1 (
      .clock(clock), .reset(reset),
      .pressurize_req(pressurize_req), .evacuate_req(evacuate_req),
      .inner_closed(inner_closed), .outer_closed(outer_closed),
      .pressurized(pressurized[1]), .busy(busy[1]), .done(done[1]),
      .reject(reject[1]), .fault(fault[1]),
      .inner_unlock(inner_unlock[1]), .outer_unlock(outer_unlock[1]),
      .hex_count(hex_count[1])
   );

   int fill_n [2] = '{7, 1};
   int evac_n [2] = '{8, 3};

   // Model: settled side of the chamber plus busy cycles still to run
   bit m_settled [2];
   int m_rem     [2];
   bit m_done    [2];
   bit m_rej     [2];
   bit m_fault   [2];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [6:0] seg(input int d);
      case (d)
         0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
         4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
         8: return 7'h00;  9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   task automatic model_step(input int i, input bit p, input bit e, input bit ic,
                             input bit oc, input bit rst);
      bit closed;
      m_done[i]  = 1'b0;
      m_fault[i] = 1'b0;
      m_rej[i]   = 1'b0;
      if (rst) begin
         m_settled[i] = 1'b0;
         m_rem[i]     = 0;
         return;
      end
      closed   = ic && oc;
      m_rej[i] = (p || e) && (m_rem[i] > 0 || (p && e) || (p && m_settled[i]) ||
                              (e && !m_settled[i]) || !closed);
      if (m_rem[i] > 0) begin
         if (!closed) begin
            m_fault[i] = 1'b1;
            m_rem[i]   = 0;
         end else if (m_rem[i] == 1) begin
            m_done[i]    = 1'b1;
            m_settled[i] = !m_settled[i];
            m_rem[i]     = 0;
         end else begin
            m_rem[i]--;
         end
      end else if (!m_rej[i]) begin
         if (p)      m_rem[i] = fill_n[i];
         else if (e) m_rem[i] = evac_n[i];
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 2; i++) begin
         bit         b;
         logic [6:0] exp_hex;
         b = (m_rem[i] > 0);
`ifdef CHAMBER_SEQ_HEX_EN
         exp_hex = b ? seg(m_rem[i] - 1) : 7'h7F;
`else
         exp_hex = 7'h7F;
`endif
         chk($sformatf("busy%0d", i),         7'(busy[i]),         7'(b));
         chk($sformatf("pressurized%0d", i),  7'(pressurized[i]),  7'(m_settled[i] && !b));
         chk($sformatf("inner_unlock%0d", i), 7'(inner_unlock[i]), 7'(m_settled[i] && !b));
         chk($sformatf("outer_unlock%0d", i), 7'(outer_unlock[i]), 7'(!m_settled[i] && !b));
         chk($sformatf("done%0d", i),         7'(done[i]),         7'(m_done[i]));
         chk($sformatf("reject%0d", i),       7'(reject[i]),       7'(m_rej[i]));
         chk($sformatf("fault%0d", i),        7'(fault[i]),        7'(m_fault[i]));
         chk($sformatf("hex%0d", i),          hex_count[i],        exp_hex);
      end
   endtask

   task automatic cycle(input bit p, input bit e, input bit ic, input bit oc, input bit rst);
      pressurize_req = p;
      evacuate_req   = e;
      inner_closed   = ic;
      outer_closed   = oc;
      reset          = rst;
      @(posedge clock);
      for (int i = 0; i < 2; i++) model_step(i, p, e, ic, oc, rst);
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         m_settled[i] = 1'b0; m_rem[i] = 0;
         m_done[i] = 1'b0; m_rej[i] = 1'b0; m_fault[i] = 1'b0;
      end
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      idle(1);
      // fill, then evacuate with a repeat request mid-sequence
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      idle(9);
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      idle(2);
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      idle(8);
      // outer port dropped partway through a fill
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      idle(3);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(2);
      // simultaneous requests, open port, wrong-direction request
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      // held request, then reset partway through an evacuation
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      idle(8);
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      idle(3);
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      idle(2);
      for (int n = 0; n < 4000; n++) begin
         cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 39) != 0), ($urandom_range(0, 39) != 0),
               ($urandom_range(0, 299) == 0));
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
